// File: rtl/vgc_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module   : vgc_fetch_bridge
// Purpose  : Serves 32-bit Super Hires VGC word fetches from a 16-bit shared
//            video memory port. Each fetch is two reads, low half then high
//            half. The word is presented atomically. A one-deep pending slot
//            absorbs strobes that arrive while busy. Deadline misses and
//            dropped strobes are counted with saturation.
// Revision : 1.0 - initial release
// ============================================================================
module vgc_fetch_bridge #(
   parameter logic [15:0] BASE_ADDR = 16'h2000,
   parameter int unsigned DEADLINE  = 12
) (
   input  logic        clk_pixel,
   input  logic        reset,
   input  logic        vgc_active_i,
   input  logic        vgc_rd_i,
   input  logic [12:0] vgc_address_i,
   output logic [31:0] vgc_data_o,
   output logic        mem_req_o,
   output logic [15:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [15:0] mem_data_i,
   output logic        late_o,
   output logic [7:0]  late_count_o,
   output logic [7:0]  drop_count_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ_LO = 2'd1,
      ST_REQ_HI = 2'd2
   } state_t;

   localparam logic [7:0] c_deadline = 8'(DEADLINE);

   state_t      state_q, state_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] lo_q, lo_d;
   logic [31:0] data_q, data_d;
   logic [7:0]  cur_age_q, cur_age_d;
   logic        pend_valid_q, pend_valid_d;
   logic [12:0] pend_addr_q, pend_addr_d;
   logic [7:0]  pend_age_q, pend_age_d;
   logic [7:0]  late_cnt_q, late_cnt_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;

   logic w_strobe;
   logic w_cur_hit;
   logic w_pend_hit;

   // Byte address of the low half of a VGC word; wraps modulo 2^16.
   function automatic logic [15:0] word_byte_addr(input logic [12:0] a);
      return BASE_ADDR + {1'b0, a, 2'b00};
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Age reaches the deadline while the word is still undelivered. The active
   // fetch is always older than the pending one, so both never hit together.
   always_comb begin
      w_strobe   = vgc_rd_i && vgc_active_i;
      w_cur_hit  = (state_q != ST_IDLE) && (cur_age_q == c_deadline);
      w_pend_hit = pend_valid_q && (pend_age_q == c_deadline);
   end

   // Next-state, handshake sequencing, pending slot and counters.
   always_comb begin
      state_d      = state_q;
      mem_addr_d   = mem_addr_q;
      lo_d         = lo_q;
      data_d       = data_q;
      cur_age_d    = (state_q != ST_IDLE) ? sat_inc(cur_age_q) : cur_age_q;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_age_d   = pend_valid_q ? sat_inc(pend_age_q) : pend_age_q;
      late_cnt_d   = (w_cur_hit || w_pend_hit) ? sat_inc(late_cnt_q) : late_cnt_q;
      drop_cnt_d   = drop_cnt_q;

      // Busy strobes fill the pending slot or are dropped if it is occupied.
      if (w_strobe && (state_q != ST_IDLE)) begin
         if (pend_valid_q) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
         end else begin
            pend_valid_d = 1'b1;
            pend_addr_d  = vgc_address_i;
            pend_age_d   = 8'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (w_strobe) begin
               state_d    = ST_REQ_LO;
               mem_addr_d = word_byte_addr(vgc_address_i);
               cur_age_d  = 8'd1;
            end
         end
         ST_REQ_LO: begin
            if (mem_ack_i) begin
               lo_d       = mem_data_i;
               mem_addr_d = mem_addr_q + 16'd2;
               state_d    = ST_REQ_HI;
            end
         end
         ST_REQ_HI: begin
            if (mem_ack_i) begin
               data_d = {mem_data_i, lo_q};
               if (pend_valid_q) begin
                  state_d      = ST_REQ_LO;
                  mem_addr_d   = word_byte_addr(pend_addr_q);
                  cur_age_d    = sat_inc(pend_age_q);
                  pend_valid_d = 1'b0;
               end else if (w_strobe) begin
                  // A strobe coinciding with the final ack passes through the
                  // slot and starts immediately.
                  state_d      = ST_REQ_LO;
                  mem_addr_d   = word_byte_addr(vgc_address_i);
                  cur_age_d    = 8'd1;
                  pend_valid_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         mem_addr_q   <= 16'd0;
         lo_q         <= 16'd0;
         data_q       <= 32'd0;
         cur_age_q    <= 8'd0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= 13'd0;
         pend_age_q   <= 8'd0;
         late_cnt_q   <= 8'd0;
         drop_cnt_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         lo_q         <= lo_d;
         data_q       <= data_d;
         cur_age_q    <= cur_age_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_age_q   <= pend_age_d;
         late_cnt_q   <= late_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   // Request is a level held through both beats of a fetch.
   always_comb begin
      mem_req_o    = (state_q != ST_IDLE);
      mem_addr_o   = mem_addr_q;
      vgc_data_o   = data_q;
      late_o       = w_cur_hit || w_pend_hit;
      late_count_o = late_cnt_q;
      drop_count_o = drop_cnt_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_vgc_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_vgc_fetch_bridge
// Purpose  : Directed self-checking bench for vgc_fetch_bridge. Inputs are
//            driven on the falling edge and outputs are sampled there too.
//            "Cycle N" is the falling edge after the Nth rising edge that
//            follows the strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vgc_fetch_bridge;

   logic        clk_pixel;
   logic        reset;
   logic        vgc_active_i;
   logic        vgc_rd_i;
   logic [12:0] vgc_address_i;
   logic [31:0] vgc_data_o;
   logic        mem_req_o;
   logic [15:0] mem_addr_o;
   logic        mem_ack_i;
   logic [15:0] mem_data_i;
   logic        late_o;
   logic [7:0]  late_count_o;
   logic [7:0]  drop_count_o;

   logic        resp_ack, stray_ack;
   logic [15:0] resp_data, stray_data;
   int          lat;
   int          cmps;
   int          errs;

   assign mem_ack_i  = resp_ack | stray_ack;
   assign mem_data_i = stray_ack ? stray_data : resp_data;

   vgc_fetch_bridge dut (
      .clk_pixel     (clk_pixel),
      .reset         (reset),
      .vgc_active_i  (vgc_active_i),
      .vgc_rd_i      (vgc_rd_i),
      .vgc_address_i (vgc_address_i),
      .vgc_data_o    (vgc_data_o),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ack_i     (mem_ack_i),
      .mem_data_i    (mem_data_i),
      .late_o        (late_o),
      .late_count_o  (late_count_o),
      .drop_count_o  (drop_count_o)
   );

   initial begin
      clk_pixel = 1'b0;
      forever #5 clk_pixel = ~clk_pixel;
   end

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      case (a)
         16'h2000: return 16'h1234;
         16'h2002: return 16'hABCD;
         default:  return a ^ 16'hC3C3;
      endcase
   endfunction

   // Memory model: acknowledges after 'lat' waiting cycles per beat.
   initial begin
      int cnt;
      cnt = 0;
      resp_ack = 1'b0;
      resp_data = 16'd0;
      forever begin
         @(negedge clk_pixel);
         if (mem_req_o && !reset) begin
            if (cnt == lat) begin
               resp_ack = 1'b1;
               resp_data = mem_val(mem_addr_o);
               cnt = 0;
            end else begin
               resp_ack = 1'b0;
               cnt++;
            end
         end else begin
            resp_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   task automatic do_reset;
      @(negedge clk_pixel);
      reset = 1'b1; vgc_rd_i = 1'b0; vgc_active_i = 1'b1; stray_ack = 1'b0;
      @(negedge clk_pixel);
      @(negedge clk_pixel);
      reset = 1'b0;
   endtask

   // Called at cycle 0; returns at cycle 1.
   task automatic strobe(input logic [12:0] a);
      vgc_rd_i = 1'b1; vgc_address_i = a;
      @(negedge clk_pixel);
      vgc_rd_i = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk_pixel);
      reset = 1'b1; vgc_rd_i = 1'b0; vgc_active_i = 1'b1; stray_ack = 1'b0;
      @(negedge clk_pixel);
      cmps++; if (vgc_data_o !== 32'd0) begin errs++; $display("FAIL rst_data: got %h want 0", vgc_data_o); end
      cmps++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
      cmps++; if (mem_addr_o !== 16'd0) begin errs++; $display("FAIL rst_addr: got %h want 0", mem_addr_o); end
      cmps++; if (late_o !== 1'b0) begin errs++; $display("FAIL rst_late: got %b want 0", late_o); end
      cmps++; if (late_count_o !== 8'd0) begin errs++; $display("FAIL rst_late_cnt: got %0d want 0", late_count_o); end
      cmps++; if (drop_count_o !== 8'd0) begin errs++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_count_o); end
      reset = 1'b0;
   endtask

   task automatic test_basic;
      lat = 0;
      do_reset;
      strobe(13'd0);
      cmps++; if (mem_req_o !== 1'b1) begin errs++; $display("FAIL basic_req1: got %b want 1", mem_req_o); end
      cmps++; if (mem_addr_o !== 16'h2000) begin errs++; $display("FAIL basic_addr_lo0: got %h want 2000", mem_addr_o); end
      @(negedge clk_pixel);
      cmps++; if (mem_addr_o !== 16'h2002) begin errs++; $display("FAIL basic_addr_hi0: got %h want 2002", mem_addr_o); end
      cmps++; if (vgc_data_o !== 32'd0) begin errs++; $display("FAIL basic_no_half: got %h want 0", vgc_data_o); end
      @(negedge clk_pixel);
      cmps++; if (vgc_data_o !== 32'hABCD1234) begin errs++; $display("FAIL basic_word0: got %h want ABCD1234", vgc_data_o); end
      cmps++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL basic_req_idle: got %b want 0", mem_req_o); end
      repeat (13) @(negedge clk_pixel);
      strobe(13'd1);
      cmps++; if (mem_addr_o !== 16'h2004) begin errs++; $display("FAIL basic_addr_lo1: got %h want 2004", mem_addr_o); end
      @(negedge clk_pixel);
      cmps++; if (mem_addr_o !== 16'h2006) begin errs++; $display("FAIL basic_addr_hi1: got %h want 2006", mem_addr_o); end
      @(negedge clk_pixel);
      cmps++; if (vgc_data_o !== 32'hE3C5E3C7) begin errs++; $display("FAIL basic_word1: got %h want E3C5E3C7", vgc_data_o); end
      cmps++; if (late_count_o !== 8'd0) begin errs++; $display("FAIL basic_late_cnt: got %0d want 0", late_count_o); end
   endtask

   task automatic test_late;
      int pulses;
      pulses = 0;
      lat = 5;
      do_reset;
      strobe(13'd8191);
      cmps++; if (mem_addr_o !== 16'h9FFC) begin errs++; $display("FAIL late_addr_lo: got %h want 9FFC", mem_addr_o); end
      for (int c = 1; c <= 13; c++) begin
         if (late_o) pulses++;
         if (c == 7) begin
            cmps++; if (mem_addr_o !== 16'h9FFE) begin errs++; $display("FAIL late_addr_hi: got %h want 9FFE", mem_addr_o); end
         end
         if (c == 11) begin
            cmps++; if (late_o !== 1'b0) begin errs++; $display("FAIL late_early: got %b want 0", late_o); end
         end
         if (c == 12) begin
            cmps++; if (late_o !== 1'b1) begin errs++; $display("FAIL late_pulse12: got %b want 1", late_o); end
            cmps++; if (vgc_data_o !== 32'd0) begin errs++; $display("FAIL late_undelivered: got %h want 0", vgc_data_o); end
         end
         if (c < 13) @(negedge clk_pixel);
      end
      cmps++; if (vgc_data_o !== 32'h5C3D5C3F) begin errs++; $display("FAIL late_word: got %h want 5C3D5C3F", vgc_data_o); end
      cmps++; if (late_count_o !== 8'd1) begin errs++; $display("FAIL late_cnt: got %0d want 1", late_count_o); end
      cmps++; if (pulses !== 1) begin errs++; $display("FAIL late_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_back_to_back;
      lat = 7;
      do_reset;
      for (int c = 0; c <= 34; c++) begin
         vgc_rd_i = (c == 0) || (c == 2) || (c == 4);
         vgc_address_i = (c == 0) ? 13'd10 : (c == 2) ? 13'd20 : 13'd30;
         if (c == 5) begin
            cmps++; if (drop_count_o !== 8'd1) begin errs++; $display("FAIL b2b_drop5: got %0d want 1", drop_count_o); end
         end
         if (c == 16) begin
            cmps++; if (vgc_data_o !== 32'd0) begin errs++; $display("FAIL b2b_data16: got %h want 0", vgc_data_o); end
         end
         if (c == 17) begin
            cmps++; if (vgc_data_o !== 32'hE3E9E3EB) begin errs++; $display("FAIL b2b_word_a: got %h want E3E9E3EB", vgc_data_o); end
            cmps++; if (mem_addr_o !== 16'h2050) begin errs++; $display("FAIL b2b_pend_addr: got %h want 2050", mem_addr_o); end
         end
         if (c == 33) begin
            cmps++; if (vgc_data_o !== 32'hE391E393) begin errs++; $display("FAIL b2b_word_b: got %h want E391E393", vgc_data_o); end
         end
         if (c == 34) begin
            cmps++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL b2b_idle: got %b want 0", mem_req_o); end
            cmps++; if (drop_count_o !== 8'd1) begin errs++; $display("FAIL b2b_drop: got %0d want 1", drop_count_o); end
            cmps++; if (late_count_o !== 8'd2) begin errs++; $display("FAIL b2b_late_cnt: got %0d want 2", late_count_o); end
            cmps++; if (vgc_data_o !== 32'hE391E393) begin errs++; $display("FAIL b2b_hold: got %h want E391E393", vgc_data_o); end
         end
         @(negedge clk_pixel);
      end
      vgc_rd_i = 1'b0;
   endtask

   task automatic test_active;
      logic saw_req;
      lat = 3;
      do_reset;
      vgc_active_i = 1'b0;
      strobe(13'd7);
      saw_req = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (mem_req_o) saw_req = 1'b1;
         @(negedge clk_pixel);
      end
      cmps++; if (saw_req !== 1'b0) begin errs++; $display("FAIL act_ignored: got %b want 0", saw_req); end
      cmps++; if (drop_count_o !== 8'd0) begin errs++; $display("FAIL act_drop0: got %0d want 0", drop_count_o); end
      vgc_active_i = 1'b1;
      strobe(13'd5);
      vgc_active_i = 1'b0;
      @(negedge clk_pixel);
      vgc_rd_i = 1'b1; vgc_address_i = 13'd9;
      @(negedge clk_pixel);
      vgc_rd_i = 1'b0;
      repeat (6) @(negedge clk_pixel);
      cmps++; if (vgc_data_o !== 32'hE3D5E3D7) begin errs++; $display("FAIL act_word: got %h want E3D5E3D7", vgc_data_o); end
      @(negedge clk_pixel);
      cmps++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL act_no_pend: got %b want 0", mem_req_o); end
      cmps++; if (drop_count_o !== 8'd0) begin errs++; $display("FAIL act_drop1: got %0d want 0", drop_count_o); end
      vgc_active_i = 1'b1;
   endtask

   task automatic test_reset_mid;
      lat = 3;
      do_reset;
      strobe(13'd2);
      repeat (4) @(negedge clk_pixel);
      cmps++; if (mem_addr_o !== 16'h200A) begin errs++; $display("FAIL rmid_hi_addr: got %h want 200A", mem_addr_o); end
      cmps++; if (mem_req_o !== 1'b1) begin errs++; $display("FAIL rmid_req_hi: got %b want 1", mem_req_o); end
      reset = 1'b1;
      @(negedge clk_pixel);
      cmps++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL rmid_req_drop: got %b want 0", mem_req_o); end
      cmps++; if (mem_addr_o !== 16'd0) begin errs++; $display("FAIL rmid_addr: got %h want 0", mem_addr_o); end
      reset = 1'b0;
      stray_ack = 1'b1; stray_data = 16'hDEAD;
      @(negedge clk_pixel);
      stray_ack = 1'b0;
      @(negedge clk_pixel);
      cmps++; if (vgc_data_o !== 32'd0) begin errs++; $display("FAIL rmid_stray: got %h want 0", vgc_data_o); end
      cmps++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL rmid_idle: got %b want 0", mem_req_o); end
   endtask

   task automatic test_saturation;
      int pulses;
      logic timed_out;
      pulses = 0;
      timed_out = 1'b0;
      lat = 6;
      do_reset;
      for (int i = 0; i < 300; i++) begin
         strobe(13'(i));
         for (int w = 0; w < 40 && mem_req_o; w++) begin
            if (late_o) pulses++;
            @(negedge clk_pixel);
         end
         if (mem_req_o) begin
            cmps++; errs++; timed_out = 1'b1;
            $display("FAIL sat_timeout: req still %b at fetch %0d, want 0", mem_req_o, i);
            break;
         end
         if (i == 253) begin
            cmps++; if (late_count_o !== 8'd254) begin errs++; $display("FAIL sat_cnt254: got %0d want 254", late_count_o); end
         end
      end
      if (!timed_out) begin
         cmps++; if (late_count_o !== 8'd255) begin errs++; $display("FAIL sat_cnt: got %0d want 255", late_count_o); end
         cmps++; if (pulses !== 300) begin errs++; $display("FAIL sat_pulses: got %0d want 300", pulses); end
      end
   endtask

   initial begin
      cmps = 0; errs = 0; lat = 0;
      reset = 1'b1; vgc_active_i = 1'b1; vgc_rd_i = 1'b0; vgc_address_i = 13'd0;
      stray_ack = 1'b0; stray_data = 16'd0;
      test_reset;
      test_basic;
      test_late;
      test_back_to_back;
      test_active;
      test_reset_mid;
      test_saturation;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
`default_nettype wire
